// File: rtl/ppu_a12_gen.sv
// ppu_a12_gen
//   PPU A12 pattern generator. Runs NTSC-style dot/scanline counters and
//   drives a registered A12 level that mirrors the pattern-table fetches of a
//   real PPU. Background fetches (dots 1..256, 321..336) follow bg_hi, and
//   sprite fetches (dots 257..320) follow spr_hi. In each 8-dot fetch group,
//   the last four dots are the pattern low/high fetches. This block is the
//   source side of mapper scanline-IRQ logic.
//
// Optional feature:
//   A12_GEN_ODD_SKIP_EN - when defined, an odd frame with rendering enabled
//   leaves the pre-render line after dot 339. Dot 340 is skipped.
//
// Ports:
//   clk          single clock
//   map_rst_n    synchronous active-low reset
//   render_en    rendering enabled; sampled on every dot_ce
//   bg_hi        background pattern table at $1000; sampled on every dot_ce
//   spr_hi       sprite pattern table at $1000; sampled on every dot_ce
//   ppu_a12      registered A12 level; changes on the same edge as dot
//   dot_ce       one-clk strobe per PPU dot
//   dot          current dot, 0..DOTS_PER_LINE-1
//   line         current line, 0..LINES_PER_FRAME-1 (last line is pre-render)
//   frame_odd    odd-frame flag
//   frame_start  one-clk pulse on the dot_ce that enters line 0, dot 0
module ppu_a12_gen #(
   parameter int CLK_PER_DOT     = 4,
   parameter int DOTS_PER_LINE   = 341,
   parameter int LINES_PER_FRAME = 262,
   parameter int VIS_LINES       = 240
) (
   input  logic       clk,
   input  logic       map_rst_n,
   input  logic       render_en,
   input  logic       bg_hi,
   input  logic       spr_hi,
   output logic       ppu_a12,
   output logic       dot_ce,
   output logic [8:0] dot,
   output logic [8:0] line,
   output logic       frame_odd,
   output logic       frame_start
);

   localparam int            PW        = $clog2(CLK_PER_DOT);
   localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_PER_DOT - 1);
   localparam logic [8:0]    DOT_LAST  = 9'(DOTS_PER_LINE - 1);
   localparam logic [8:0]    LINE_LAST = 9'(LINES_PER_FRAME - 1);
   localparam logic [8:0]    VIS_END   = 9'(VIS_LINES);

   // The fetch windows are fixed by PPU timing. They stay fixed even if
   // the counter lengths are changed.
   localparam logic [8:0] BG_A_FIRST = 9'd1;
   localparam logic [8:0] BG_A_LAST  = 9'd256;
   localparam logic [8:0] SPR_FIRST  = 9'd257;
   localparam logic [8:0] SPR_LAST   = 9'd320;
   localparam logic [8:0] BG_B_FIRST = 9'd321;
   localparam logic [8:0] BG_B_LAST  = 9'd336;
`ifdef A12_GEN_ODD_SKIP_EN
   localparam logic [8:0] SKIP_DOT   = 9'd339;
`endif

   logic [PW-1:0] pre;

   logic       pre_wrap;
   logic       last_line;
   logic       odd_skip;
   logic       line_end;
   logic [8:0] dot_nx;
   logic [8:0] line_nx;
   logic       odd_nx;
   logic       rend_line;
   logic [2:0] grp;
   logic       pat_slot;
   logic       bg_zone;
   logic       spr_zone;
   logic       a12_nx;
   logic       top_nx;

   // Next dot/line and the A12 level for the dot being entered. All of
   // these are evaluated against the incoming position, so ppu_a12 lines
   // up with the dot it belongs to.
   always_comb begin
      pre_wrap  = (pre == PRE_LAST);
      last_line = (line == LINE_LAST);
      odd_skip  = 1'b0;
`ifdef A12_GEN_ODD_SKIP_EN
      odd_skip  = last_line && frame_odd && render_en && (dot == SKIP_DOT);
`endif
      line_end  = (dot == DOT_LAST) || odd_skip;

      dot_nx  = line_end ? 9'd0 : dot + 9'd1;
      line_nx = line;
      odd_nx  = frame_odd;
      if (line_end) begin
         if (last_line) begin
            line_nx = 9'd0;
            odd_nx  = ~frame_odd;
         end else begin
            line_nx = line + 9'd1;
         end
      end
      top_nx = (dot_nx == 9'd0) && (line_nx == 9'd0);

      rend_line = render_en && ((line_nx < VIS_END) || (line_nx == LINE_LAST));

      // The fetch group position is (dot-1) mod 8. Positions 4..7 are the
      // pattern fetches, and bit 2 of the group position marks them. At dot
      // 0 this wraps to 7, but no fetch window covers dot 0.
      grp      = dot_nx[2:0] - 3'd1;
      pat_slot = grp[2];
      bg_zone  = ((dot_nx >= BG_A_FIRST) && (dot_nx <= BG_A_LAST)) ||
                 ((dot_nx >= BG_B_FIRST) && (dot_nx <= BG_B_LAST));
      spr_zone = (dot_nx >= SPR_FIRST) && (dot_nx <= SPR_LAST);

      a12_nx = rend_line && pat_slot &&
               ((bg_zone && bg_hi) || (spr_zone && spr_hi));
   end

   always_ff @(posedge clk) begin
      if (!map_rst_n) begin
         pre         <= '0;
         dot         <= 9'd0;
         line        <= 9'd0;
         frame_odd   <= 1'b0;
         ppu_a12     <= 1'b0;
         dot_ce      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         dot_ce      <= pre_wrap;
         frame_start <= pre_wrap && top_nx;
         if (pre_wrap) begin
            pre       <= '0;
            dot       <= dot_nx;
            line      <= line_nx;
            frame_odd <= odd_nx;
            ppu_a12   <= a12_nx;
         end else begin
            pre <= pre + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ppu_a12_gen.sv
// tb_ppu_a12_gen
//   Bench for ppu_a12_gen. The frame is shortened to 11 lines, so line 10 is
//   the pre-render line. The dot length stays at 341 and CLK_PER_DOT is 2.
//   This keeps several whole frames inside a short run. A reference model
//   follows the rules for dots, lines and A12 targets and is compared with the
//   DUT outputs on every clock. A table of pattern-table settings gives the
//   per-frame edge counts, edge positions and frame lengths. Hand-written
//   sequences cover reset latency and a mid-line disable.
module tb_ppu_a12_gen;

   localparam int CPD      = 2;
   localparam int DPL      = 341;
   localparam int LPF      = 11;
   localparam int VIS      = 8;
   localparam int MID_LINE = 10;
   localparam int FRAME_DOTS = DPL * LPF;

   logic       clk;
   logic       map_rst_n;
   logic       render_en;
   logic       bg_hi;
   logic       spr_hi;
   logic       ppu_a12;
   logic       dot_ce;
   logic [8:0] dot;
   logic [8:0] line;
   logic       frame_odd;
   logic       frame_start;

   ppu_a12_gen #(
      .CLK_PER_DOT    (CPD),
      .DOTS_PER_LINE  (DPL),
      .LINES_PER_FRAME(LPF),
      .VIS_LINES      (VIS)
   ) dut (
      .clk        (clk),
      .map_rst_n  (map_rst_n),
      .render_en  (render_en),
      .bg_hi      (bg_hi),
      .spr_hi     (spr_hi),
      .ppu_a12    (ppu_a12),
      .dot_ce     (dot_ce),
      .dot        (dot),
      .line       (line),
      .frame_odd  (frame_odd),
      .frame_start(frame_start)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int pre;
      int dot;
      int line;
      bit odd;
      bit a12;
      bit ce;
      bit fs;
   } mdl_t;

   mdl_t m;

   function automatic bit is_rline(int l);
      return (l < VIS) || (l == LPF - 1);
   endfunction

   function automatic bit a12_rule(int l, int d, bit ren, bit bg, bit spr);
      int g;
      bit pat;
      if (!ren || !is_rline(l) || d == 0) return 1'b0;
      g   = (d - 1) % 8;
      pat = (g >= 4);
      if ((d >= 1 && d <= 256) || (d >= 321 && d <= 336)) return pat && bg;
      if (d >= 257 && d <= 320) return pat && spr;
      return 1'b0;
   endfunction

   function automatic mdl_t model_step(mdl_t s, bit rst_n, bit ren, bit bg, bit spr);
      mdl_t n = s;
      bit skip;
      if (!rst_n) begin
         n = '{default: 0};
         return n;
      end
      n.ce = 1'b0;
      n.fs = 1'b0;
      if (s.pre < CPD - 1) begin
         n.pre = s.pre + 1;
         return n;
      end
      n.pre = 0;
      n.ce  = 1'b1;
      skip  = 1'b0;
`ifdef A12_GEN_ODD_SKIP_EN
      skip  = (s.line == LPF - 1) && s.odd && ren && (s.dot == 339);
`endif
      if (s.dot == DPL - 1 || skip) begin
         n.dot  = 0;
         n.line = (s.line + 1) % LPF;
         if (n.line == 0) n.odd = !s.odd;
      end else begin
         n.dot = s.dot + 1;
      end
      n.a12 = a12_rule(n.line, n.dot, ren, bg, spr);
      n.fs  = (n.line == 0) && (n.dot == 0);
      return n;
   endfunction

   initial begin
      m = '{default: 0};
      forever begin
         @(posedge clk);
         m = model_step(m, map_rst_n, render_en, bg_hi, spr_hi);
      end
   end

   // ---------------- per-clock scoreboard against the model ----------------
   bit          chk_en = 1'b0;
   logic [21:0] exp_v;
   logic [21:0] got_v;

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         exp_v = {m.a12, m.ce, 9'(m.dot), 9'(m.line), m.odd, m.fs};
         got_v = {ppu_a12, dot_ce, dot, line, frame_odd, frame_start};
         total++;
         if (got_v !== exp_v) begin
            bad++;
            $display("FAIL model_cmp t=%0t got a12=%0b ce=%0b dot=%0d line=%0d odd=%0b fs=%0b want a12=%0b ce=%0b dot=%0d line=%0d odd=%0b fs=%0b",
                     $time, ppu_a12, dot_ce, dot, line, frame_odd, frame_start,
                     m.a12, m.ce, m.dot, m.line, m.odd, m.fs);
         end
      end
   end

   // ---------------- frame statistics monitor ----------------
   int         clk_cnt = 0;
   int         dot_cnt = 0;
   int         len_clks = 0;
   int         len_dots = 0;
   int         fs_cnt = 0;
   int         edge_cnt[LPF];
   logic [8:0] edge_q0[$];
   logic [8:0] exp_q[$];
   int         win_hi0 = 0;
   int         hi_frame = 0;
   int         mid_late_edges = 0;
   int         mid_late_hi = 0;
   bit         prev_a12 = 1'b0;

   initial forever begin
      @(negedge clk);
      if (!map_rst_n) begin
         clk_cnt  = 0;
         dot_cnt  = 0;
         prev_a12 = 1'b0;
      end else begin
         clk_cnt++;
         if (dot_ce) dot_cnt++;
         if (ppu_a12 && !prev_a12) begin
            edge_cnt[m.line]++;
            if (m.line == 0) edge_q0.push_back(9'(m.dot));
            if (m.line == MID_LINE && m.dot >= 301) mid_late_edges++;
         end
         if (dot_ce && ppu_a12) begin
            hi_frame++;
            if (m.line == 0 && m.dot >= 257 && m.dot <= 320) win_hi0++;
            if (m.line == MID_LINE && m.dot >= 301) mid_late_hi++;
         end
         prev_a12 = ppu_a12;
         if (frame_start) begin
            len_dots = dot_cnt;
            len_clks = clk_cnt;
            dot_cnt  = 0;
            clk_cnt  = 0;
            fs_cnt++;
         end
      end
   end

   task automatic clear_stats();
      for (int i = 0; i < LPF; i++) edge_cnt[i] = 0;
      edge_q0.delete();
      win_hi0        = 0;
      hi_frame       = 0;
      mid_late_edges = 0;
      mid_late_hi    = 0;
   endtask

   task automatic wait_frame(output bit ok);
      int start;
      start = fs_cnt;
      ok    = 1'b0;
      for (int i = 0; i < 2 * FRAME_DOTS * CPD; i++) begin
         @(negedge clk);
         #1;
         if (fs_cnt != start) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- table of pattern-table settings ----------------
   typedef struct {
      bit ren;
      bit bg;
      bit spr;
      int edges_rl;    // rising edges on each rendering line
      int first_dot;   // first edge dot on line 0, then every 8 dots
      int n_main;
      int tail_first;  // second run of edges (late background fetches)
      int n_tail;
      int win_hi;      // line-0 dots 257..320 with A12 high
      int hi_rl;       // dots with A12 high on each rendering line
   } row_t;

   row_t rows[4];

   // ---------------- main sequence ----------------
   initial begin
      bit ok;
      int n;
      int exp_len;
      int frame_idx;
      bit q_ok;
      int rst_at;

      map_rst_n = 1'b0;
      render_en = 1'b0;
      bg_hi     = 1'b0;
      spr_hi    = 1'b0;

      rows[0] = '{1'b1, 1'b0, 1'b1,  8, 261,  8,   0, 0, 32,  32};
      rows[1] = '{1'b1, 1'b1, 1'b0, 34,   5, 32, 325, 2,  0, 136};
      rows[2] = '{1'b0, 1'b1, 1'b1,  0,   0,  0,   0, 0,  0,   0};
      rows[3] = '{1'b0, 1'b0, 1'b0,  0,   0,  0,   0, 0,  0,   0};

      // Reset is held for 5 clocks, then checked.
      @(negedge clk);
      #1;
      chk_en = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      total++;
      if ({ppu_a12, dot_ce, dot, line, frame_odd, frame_start} !== 22'd0) begin
         bad++;
         $display("FAIL reset_state got=%h want=0",
                  {ppu_a12, dot_ce, dot, line, frame_odd, frame_start});
      end
      map_rst_n = 1'b1;

      n = 0;
      while (n < 16) begin
         @(negedge clk);
         #1;
         n++;
         if (dot_ce === 1'b1) break;
      end
      check("first_ce_latency", n, CPD);
      check("dot_after_first_ce", int'(dot), 1);
      check("line_after_first_ce", int'(line), 0);

      // Table rows. Each row runs one whole frame.
      frame_idx = 0;
      for (int r = 0; r < 4; r++) begin
         render_en = rows[r].ren;
         bg_hi     = rows[r].bg;
         spr_hi    = rows[r].spr;
         clear_stats();
         wait_frame(ok);
         check("frame_seen", int'(ok), 1);

         exp_len = FRAME_DOTS;
`ifdef A12_GEN_ODD_SKIP_EN
         if (rows[r].ren && (frame_idx % 2 == 1)) exp_len = FRAME_DOTS - 1;
`endif
         check("frame_dots", len_dots, exp_len);
         check("frame_clks", len_clks, exp_len * CPD);

         for (int l = 0; l < LPF; l++)
            check($sformatf("edges_row%0d_line%0d", r, l), edge_cnt[l],
                  is_rline(l) ? rows[r].edges_rl : 0);

         exp_q.delete();
         for (int k = 0; k < rows[r].n_main; k++) exp_q.push_back(9'(rows[r].first_dot + 8 * k));
         for (int k = 0; k < rows[r].n_tail; k++) exp_q.push_back(9'(rows[r].tail_first + 8 * k));
         q_ok = (edge_q0.size() == exp_q.size());
         if (q_ok)
            for (int k = 0; k < exp_q.size(); k++)
               if (edge_q0[k] != exp_q[k]) q_ok = 1'b0;
         total++;
         if (!q_ok) begin
            bad++;
            $display("FAIL edge_dots_row%0d got n=%0d first=%0d want n=%0d first=%0d", r,
                     edge_q0.size(), (edge_q0.size() > 0) ? int'(edge_q0[0]) : -1,
                     exp_q.size(), (exp_q.size() > 0) ? int'(exp_q[0]) : -1);
         end

         check($sformatf("spr_window_hi_row%0d", r), win_hi0, rows[r].win_hi);
         check($sformatf("frame_hi_dots_row%0d", r), hi_frame, rows[r].hi_rl * (VIS + 1));
         frame_idx++;
      end

      // Mid-line disable on the pre-render line (line 10) at dot 300.
      render_en = 1'b1;
      bg_hi     = 1'b0;
      spr_hi    = 1'b1;
      clear_stats();
      ok = 1'b0;
      for (int i = 0; i < 2 * FRAME_DOTS * CPD; i++) begin
         @(negedge clk);
         #1;
         if (m.line == MID_LINE && m.dot == 300) begin
            ok = 1'b1;
            break;
         end
      end
      check("mid_reach_dot300", int'(ok), 1);
      render_en = 1'b0;
      wait_frame(ok);
      check("mid_frame_seen", int'(ok), 1);
      check("mid_line_edges", edge_cnt[MID_LINE], 5);
      check("mid_late_edges", mid_late_edges, 0);
      check("mid_late_hi", mid_late_hi, 0);

      // Random inputs with one short reset in the middle. Every clock is
      // checked against the model.
      rst_at = $urandom_range(9000, 10000);
      for (int i = 0; i < 12000; i++) begin
         @(negedge clk);
         #1;
         if ($urandom_range(0, 31) == 0) render_en = 1'($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 31) == 0) bg_hi = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 31) == 0) spr_hi = 1'($urandom_range(0, 1));
         if (i == rst_at) map_rst_n = 1'b0;
         if (i == rst_at + 2) map_rst_n = 1'b1;
      end

      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog run did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ppu_a12_gen.md
# ppu_a12_gen

PPU address-line A12 pattern generator: runs NTSC PPU dot/scanline counters and drives a registered `ppu_a12` waveform matching real rendering fetches. Background and sprite pattern fetches raise A12 according to the selected pattern tables. It is the source side of the mapper scanline-IRQ path: it feeds A12-edge-counting IRQ blocks in simulation and on-board self-test, and provides the PPU timebase for emulated-PPU configurations.

## Interface
Parameters:
- `CLK_PER_DOT`, 4: clk cycles per PPU dot; legal range 2..16.
- `DOTS_PER_LINE`, 341: dots per scanline.
- `LINES_PER_FRAME`, 262: scanlines per frame; line 261 is pre-render.
- `VIS_LINES`, 240: rendered lines 0..VIS_LINES-1.

Ports:
- `clk` in 1: single clock.
- `map_rst_n` in 1: reset, synchronous, active-low.
- `render_en` in 1: rendering enabled (background or sprites on).
- `bg_hi` in 1: background pattern table at $1000.
- `spr_hi` in 1: sprite pattern table at $1000 (8x8 sprites).
- `ppu_a12` out 1: generated A12 level, registered.
- `dot_ce` out 1: one-clk strobe per PPU dot.
- `dot` out 9: current dot, 0..DOTS_PER_LINE-1.
- `line` out 9: current line, 0..LINES_PER_FRAME-1.
- `frame_odd` out 1: odd-frame flag.
- `frame_start` out 1: one-clk pulse at line 0, dot 0.

## Operation
- Prescaler counts 0..CLK_PER_DOT-1. `dot_ce` asserts in the clk where the prescaler wraps.
- On `dot_ce`, `dot` increments. On wrap from DOTS_PER_LINE-1 to 0, `line` increments. `line` wraps 261 to 0 and toggles `frame_odd`.
- Fetch group index: g = (dot-1) mod 8, defined for dot ≥ 1.
- Rendering line: `line` < VIS_LINES or `line` == LINES_PER_FRAME-1, with `render_en` = 1.
- A12 target for the dot being entered, evaluated on rendering lines only:
  - dot 1..256 and 321..336: `bg_hi` when g ∈ {4..7} (pattern low/high fetch), else 0 (nametable/attribute fetch).
  - dot 257..320: `spr_hi` when g ∈ {4..7}, else 0 (garbage nametable fetch).
  - dot 0 and 337..340: 0.
- Non-rendering lines, or `render_en` = 0: target 0.
- `ppu_a12` loads the target in the same clk as `dot_ce`. Counters run regardless of `render_en`.
- `render_en`, `bg_hi` and `spr_hi` are sampled on each `dot_ce`. Changes mid-line take effect at the next dot; there is no line-boundary latching.
- Resulting edge pattern with `bg_hi`=0, `spr_hi`=1: 8 rising edges per rendering line, at dots 261, 269, ..., 317. Downstream IRQ counters filter these to one count per line.

## Timing
- Reset (`map_rst_n`=0 at a clk edge): prescaler, `dot`, `line`, `frame_odd`, `ppu_a12`, `dot_ce` and `frame_start` all go to 0 on that edge.
- First `dot_ce` after reset release: CLK_PER_DOT clks after the release edge.
- `ppu_a12` latency: 1 clk after the combinational dot decode, i.e. it changes coincident with `dot`.
- `frame_start`: asserts in the `dot_ce` clk where `line`/`dot` become 0/0, for one clk.
- Reset asserted mid-line wins over everything in that clk. No partial fetch state is retained.
- Frame length without odd skip: 341×262 = 89342 dots.

## Configuration
- `A12_GEN_ODD_SKIP_EN` defined:
  - On line 261 with `frame_odd`=1 and `render_en`=1 sampled at dot 339, the dot after 339 is line 0, dot 0; dot 340 is skipped.
  - The odd frame is then 89341 dots.
  - `frame_odd` toggles on that wrap as usual.
- Undefined: every frame is 89342 dots and `render_en` has no effect on frame length.

## Test plan
- Reset: hold `map_rst_n`=0 for 5 clks, then release. Required: all outputs 0; first `dot_ce` at clk 4 after release (CLK_PER_DOT=4); `dot`=1 after it.
- Sprite-table edges: `render_en`=1, `bg_hi`=0, `spr_hi`=1, run one frame. Required: exactly 8 `ppu_a12` rising edges per line for lines 0..239 and 261, at dots 261+8k (k=0..7); none on lines 240..260.
- Background-table edges: `bg_hi`=1, `spr_hi`=0. Required: rising edges at dots 5, 13, ..., 253 and 325, 333, i.e. 34 per rendering line; A12=0 across dots 257..320.
- Rendering off: `render_en`=0. Required: `ppu_a12` stays 0 for a full frame; frame = 89342 dots; `frame_start` period = 89342×CLK_PER_DOT clks.
- Odd skip, macro defined, `render_en`=1: two consecutive frames measure 89342 then 89341 dots. With `render_en`=0, both measure 89342.
- Mid-line disable: drop `render_en` at line 10, dot 300. Required: A12 goes 0 from dot 301 onward; 5 rising edges on line 10 (dots 261..293); 0 rising edges from dot 301.
